// File: rtl/mem_req_pkg.sv
// -----------------------------------------------------------------------------
// mem_req_pkg
// Shared types and default widths for the scratch-memory request sequencer.
//   state_t   : sequencer FSM states (3-bit encoding)
//   mem_req_t : request layout {we, addr, wdata} at the default widths
//   req_width : packed request width for arbitrary address/data widths
// -----------------------------------------------------------------------------
package mem_req_pkg;

    localparam int ADDR_W_DEF     = 2;
    localparam int DATA_W_DEF     = 8;
    localparam int FIFO_DEPTH_DEF = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        CAPT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    // Packed as {we, addr, wdata}; the top level uses the same bit order
    // for any parameterisation, so this struct documents the layout.
    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } mem_req_t;

    function automatic int req_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// -----------------------------------------------------------------------------
// mem_req_fifo
// Small in-order request buffer with wrap-around pointers and an occupancy
// counter. DEPTH must be a power of two so the pointers wrap naturally.
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : write wdata_i (ignored when full)
//   pop_i      : drop the head entry (ignored when empty)
//   wdata_i    : entry to push
//   rdata_o    : current head entry (valid when !empty_o)
//   full_o     : occupancy == DEPTH
//   empty_o    : occupancy == 0
// -----------------------------------------------------------------------------
module mem_req_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);

    // A push while full is dropped even if a pop happens in the same cycle;
    // the producer only sees ready from the registered count.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read when counted as valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/mem_req_ctrl.sv
// -----------------------------------------------------------------------------
// mem_req_ctrl
// Request sequencer in front of a small synchronous scratch memory. Requests
// are buffered in order, issued to the memory from registered pins (one
// strobe at a time) and read data is returned over a valid/ready handshake.
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_valid/ready   : request handshake; req_ready = FIFO not full
//   req_we/addr/wdata : request payload (wdata ignored for reads)
//   rsp_valid/ready   : read-response handshake
//   rsp_rdata         : captured read data, held while stalled
//   mem_addr          : registered memory address
//   mem_write_en      : registered write strobe (one cycle per write)
//   mem_read_en       : registered read strobe (one cycle per read)
//   mem_write_in      : registered write data
//   mem_read_out      : memory read data, valid the cycle after mem_read_en
//   busy              : FIFO non-empty or FSM not IDLE
// -----------------------------------------------------------------------------
module mem_req_ctrl
    import mem_req_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write_en,
    output logic              mem_read_en,
    output logic [DATA_W-1:0] mem_write_in,
    input  logic [DATA_W-1:0] mem_read_out,
    output logic              busy
);

    localparam int REQ_W = req_width(ADDR_W, DATA_W);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_re_q, mem_re_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [REQ_W-1:0]  fifo_wdata;
    logic [REQ_W-1:0]  fifo_head;

    logic              head_we;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;

    assign req_ready  = !fifo_full;
    assign fifo_push  = req_valid && req_ready;
    assign fifo_wdata = {req_we, req_addr, req_wdata};

    assign head_we    = fifo_head[REQ_W-1];
    assign head_addr  = fifo_head[DATA_W +: ADDR_W];
    assign head_wdata = fifo_head[DATA_W-1:0];

    mem_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Strobes are computed here for the state being entered and registered,
    // so each is high exactly while the FSM sits in WRITE or READ.
    always_comb begin
        state_d     = state_q;
        fifo_pop    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    mem_addr_d = head_addr;
                    if (head_we) begin
                        mem_wdata_d = head_wdata;
                        mem_we_d    = 1'b1;
                        state_d     = WRITE;
                    end else begin
                        mem_re_d = 1'b1;
                        state_d  = READ;
                    end
                end
            end
            WRITE: state_d = IDLE;
            READ:  state_d = CAPT;
            CAPT: begin
                // Memory data is valid the cycle after the read strobe.
                rsp_rdata_d = mem_read_out;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_wdata_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign mem_addr     = mem_addr_q;
    assign mem_write_en = mem_we_q;
    assign mem_read_en  = mem_re_q;
    assign mem_write_in = mem_wdata_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_valid    = (state_q == RESP);
    assign busy         = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_mem_req_ctrl.sv
module tb_mem_req_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_we = 1'b0;
    logic [1:0] req_addr = 2'd0;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_ready = 1'b0;
    logic [1:0] mem_addr;
    logic       mem_write_en;
    logic       mem_read_en;
    logic [7:0] mem_write_in;
    logic [7:0] mem_read_out = 8'h00;
    logic       busy;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem_model [4];

    mem_req_ctrl #(
        .ADDR_W     (2),
        .DATA_W     (8),
        .FIFO_DEPTH (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_ready    (rsp_ready),
        .mem_addr     (mem_addr),
        .mem_write_en (mem_write_en),
        .mem_read_en  (mem_read_en),
        .mem_write_in (mem_write_in),
        .mem_read_out (mem_read_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Synchronous scratch memory: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_write_en) mem_model[mem_addr] <= mem_write_in;
        if (mem_read_en)  mem_read_out <= mem_model[mem_addr];
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("en_exclusive", 8'(mem_write_en & mem_read_en), 8'h00);
        chk("rsp_no_strobe", 8'(rsp_valid & (mem_write_en | mem_read_en)), 8'h00);
    endtask

    task automatic push(input logic we, input logic [1:0] a, input logic [7:0] d);
        bit done = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        for (int i = 0; i < 30 && !done; i++) begin
            if (req_ready) done = 1'b1;
            tick();
        end
        req_valid = 1'b0;
        chk("push_accepted", 8'(done), 8'h01);
    endtask

    task automatic wait_rsp(input string tag);
        for (int i = 0; i < 40 && !rsp_valid; i++) tick();
        chk(tag, 8'(rsp_valid), 8'h01);
    endtask

    initial begin
        // ---------------- power-on reset
        tick();
        tick();
        chk("rst_req_ready", 8'(req_ready), 8'h01);
        chk("rst_rsp_valid", 8'(rsp_valid), 8'h00);
        chk("rst_rsp_rdata", rsp_rdata, 8'h00);
        chk("rst_mem_addr", 8'(mem_addr), 8'h00);
        chk("rst_mem_we", 8'(mem_write_en), 8'h00);
        chk("rst_mem_re", 8'(mem_read_en), 8'h00);
        chk("rst_mem_wdata", mem_write_in, 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        rst_n = 1'b1;
        tick();

        // ---------------- write 0xA5 @2 then read @2
        rsp_ready = 1'b1;
        push(1'b1, 2'd2, 8'hA5);                       // now N+1
        chk("wr_n1_busy", 8'(busy), 8'h01);
        chk("wr_n1_we", 8'(mem_write_en), 8'h00);
        tick();                                        // N+2
        chk("wr_n2_we", 8'(mem_write_en), 8'h01);
        chk("wr_n2_re", 8'(mem_read_en), 8'h00);
        chk("wr_n2_addr", 8'(mem_addr), 8'h02);
        chk("wr_n2_data", mem_write_in, 8'hA5);
        push(1'b0, 2'd2, 8'h00);                       // accepted at N+2, now M+1
        chk("wr_one_cycle", 8'(mem_write_en), 8'h00);
        chk("rd_m1_re", 8'(mem_read_en), 8'h00);
        tick();                                        // M+2
        chk("rd_m2_re", 8'(mem_read_en), 8'h01);
        chk("rd_m2_addr", 8'(mem_addr), 8'h02);
        tick();                                        // M+3 (CAPT)
        chk("rd_m3_re", 8'(mem_read_en), 8'h00);
        chk("rd_m3_valid", 8'(rsp_valid), 8'h00);
        tick();                                        // M+4 (RESP)
        chk("rd_m4_valid", 8'(rsp_valid), 8'h01);
        chk("rd_m4_data", rsp_rdata, 8'hA5);
        tick();
        chk("rd_m5_valid", 8'(rsp_valid), 8'h00);
        chk("rd_m5_busy", 8'(busy), 8'h00);

        // ---------------- back-pressure, then push/pop at full
        push(1'b1, 2'd1, 8'h3C);
        tick();
        tick();
        chk("bp_pre_idle", 8'(busy), 8'h00);
        rsp_ready = 1'b0;
        push(1'b0, 2'd1, 8'h00);                       // read @1, now R+1
        req_valid = 1'b1; req_we = 1'b1; req_addr = 2'd0; req_wdata = 8'h55;
        chk("bp_r1_ready", 8'(req_ready), 8'h01);
        tick();                                        // R+2
        req_we = 1'b1; req_addr = 2'd3; req_wdata = 8'h66;
        chk("bp_r2_ready", 8'(req_ready), 8'h01);
        chk("bp_r2_re", 8'(mem_read_en), 8'h01);
        tick();                                        // R+3: FIFO full
        req_we = 1'b0; req_addr = 2'd0; req_wdata = 8'h00;
        chk("bp_r3_full", 8'(req_ready), 8'h00);
        for (int i = 0; i < 5; i++) begin              // R+4 .. R+8 stalled
            tick();
            chk("bp_hold_valid", 8'(rsp_valid), 8'h01);
            chk("bp_hold_data", rsp_rdata, 8'h3C);
            chk("bp_hold_full", 8'(req_ready), 8'h00);
        end
        rsp_ready = 1'b1;                              // handshake at end of R+8
        tick();                                        // R+9: IDLE pops, full
        chk("pp_r9_valid", 8'(rsp_valid), 8'h00);
        chk("pp_r9_full", 8'(req_ready), 8'h00);
        tick();                                        // R+10: occupancy 1
        chk("pp_r10_ready", 8'(req_ready), 8'h01);
        chk("pp_r10_we", 8'(mem_write_en), 8'h01);
        chk("pp_r10_addr", 8'(mem_addr), 8'h00);
        chk("pp_r10_data", mem_write_in, 8'h55);
        tick();                                        // R+11: push taken, full
        req_valid = 1'b0;
        chk("pp_r11_full", 8'(req_ready), 8'h00);
        tick();                                        // R+12
        chk("pp_r12_we", 8'(mem_write_en), 8'h01);
        chk("pp_r12_addr", 8'(mem_addr), 8'h03);
        chk("pp_r12_data", mem_write_in, 8'h66);
        tick();
        tick();                                        // R+14
        chk("pp_r14_re", 8'(mem_read_en), 8'h01);
        chk("pp_r14_addr", 8'(mem_addr), 8'h00);
        tick();
        tick();                                        // R+16
        chk("pp_r16_valid", 8'(rsp_valid), 8'h01);
        chk("pp_r16_data", rsp_rdata, 8'h55);
        tick();
        chk("pp_r17_busy", 8'(busy), 8'h00);

        // ---------------- all addresses, in-order responses
        rsp_ready = 1'b0;
        push(1'b1, 2'd0, 8'h11);
        push(1'b1, 2'd1, 8'h22);
        push(1'b1, 2'd2, 8'h33);
        push(1'b1, 2'd3, 8'h44);
        push(1'b0, 2'd3, 8'h00);
        push(1'b0, 2'd0, 8'h00);
        wait_rsp("all_rsp0_seen");
        chk("all_rsp0_data", rsp_rdata, 8'h44);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("all_rsp0_drop", 8'(rsp_valid), 8'h00);
        wait_rsp("all_rsp1_seen");
        chk("all_rsp1_data", rsp_rdata, 8'h11);
        rsp_ready = 1'b1;
        tick();
        chk("all_done_valid", 8'(rsp_valid), 8'h00);

        // ---------------- reset mid-read with two requests queued
        push(1'b0, 2'd2, 8'h00);                       // now N+1
        push(1'b1, 2'd0, 8'h77);                       // now N+2
        push(1'b1, 2'd1, 8'h88);                       // now N+3 (CAPT, full)
        chk("mr_pre_busy", 8'(busy), 8'h01);
        chk("mr_pre_full", 8'(req_ready), 8'h00);
        rst_n = 1'b0;
        #1;
        chk("mr_busy", 8'(busy), 8'h00);
        chk("mr_rsp_valid", 8'(rsp_valid), 8'h00);
        chk("mr_rsp_rdata", rsp_rdata, 8'h00);
        chk("mr_ready", 8'(req_ready), 8'h01);
        chk("mr_mem_addr", 8'(mem_addr), 8'h00);
        chk("mr_mem_we", 8'(mem_write_en), 8'h00);
        chk("mr_mem_re", 8'(mem_read_en), 8'h00);
        chk("mr_mem_wdata", mem_write_in, 8'h00);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mr_post_busy", 8'(busy), 8'h00);
            chk("mr_post_we", 8'(mem_write_en), 8'h00);
            chk("mr_post_valid", 8'(rsp_valid), 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_req_ctrl.md
# mem_req_ctrl

Request sequencer sitting directly upstream of the 4-word × 8-bit scratch memory. It accepts read/write requests from the processor side over a valid/ready handshake and buffers them in a small in-order FIFO. It drives the memory's address, enable and write-data pins from registers, so read and write enables are never asserted together. It captures read data and returns it over a second valid/ready handshake.

## Interface
- `ADDR_W`, default 2: memory address width; must match the memory depth.
- `DATA_W`, default 8: data word width.
- `FIFO_DEPTH`, default 2: request buffer entries; power of two, ≥ 2.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted this cycle when `req_valid` is also high.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  `ADDR_W`  target word address.
- `req_wdata`  in  `DATA_W`  write data; ignored for reads.
- `rsp_valid`  out  1  read data available.
- `rsp_rdata`  out  `DATA_W`  read data.
- `rsp_ready`  in  1  consumer takes the response this cycle.
- `mem_addr`  out  `ADDR_W`  memory address; registered.
- `mem_write_en`  out  1  memory write strobe; registered.
- `mem_read_en`  out  1  memory read strobe; registered.
- `mem_write_in`  out  `DATA_W`  memory write data; registered.
- `mem_read_out`  in  `DATA_W`  memory read data.
- `busy`  out  1  high while the FIFO is non-empty or the FSM is not IDLE.

## Operation
- **Request push:** a request is pushed when `req_valid && req_ready`.
- **Ready:** `req_ready = !fifo_full`. It is combinational from the occupancy count. A push into a full FIFO never occurs, even when a pop happens in the same cycle.
- **Ordering:** the FIFO is strictly in order, so read-after-write to the same address returns the new data.
- **IDLE:** if the FIFO is non-empty, pop the head and load `mem_addr`. For a write, also load `mem_write_in` and go to WRITE. For a read, go to READ.
- **WRITE:** `mem_write_en` = 1 for exactly one cycle, then return to IDLE. Writes produce no response.
- **READ:** `mem_read_en` = 1 for exactly one cycle, then go to CAPT.
- **CAPT:** both enables are 0 and `mem_addr` is held. Register `mem_read_out` into `rsp_rdata` at the end of the cycle, then go to RESP.
- **RESP:** `rsp_valid` = 1. `rsp_rdata` holds until `rsp_ready` is high, then return to IDLE.
- **Stalls:** while stalled in RESP the FIFO keeps accepting requests until full.
- **Enable invariant:** `mem_write_en && mem_read_en` is never 1. Both are 0 in every state except their own.
- **Address wrap:** addresses are used unmodified. `ADDR_W` bits cover the full memory, so there is no out-of-range case.
- **Reset:** forces the FSM to IDLE and flushes the FIFO. An in-flight response is discarded, and a mid-operation reset drops it silently. Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `mem_addr`=0, `mem_write_en`=0, `mem_read_en`=0, `mem_write_in`=0, `busy`=0.

## Timing
- Request accepted in cycle N; the FIFO is non-empty in N+1, where IDLE pops it.
- Write: `mem_write_en` high in N+2. The FSM is back in IDLE in N+3, so the next operation's strobe is in N+4 at the earliest.
- Read: `mem_read_en` high in N+2, CAPT in N+3, `rsp_valid` high from N+4. Minimum read latency is 4 cycles from accept.
- Throughput: one write per 2 cycles; one read per 4 cycles when `rsp_ready` is held high.
- A response handshake completes in the cycle `rsp_valid && rsp_ready`. `rsp_valid` drops in the next cycle unless a new read has completed. It cannot re-assert earlier than 3 cycles later: IDLE, READ, CAPT.
- FIFO occupancy increments on push only, decrements on pop only, and is unchanged when both happen.

## Structure
- Shared package `mem_req_pkg`:
  - state enum `{IDLE, WRITE, READ, CAPT, RESP}`, 3-bit encoding;
  - struct `mem_req_t {we, addr, wdata}`;
  - default widths.
- Sub-module `mem_req_fifo`:
  - parameterised by `FIFO_DEPTH` and the request width;
  - push, pop, full and empty signals;
  - wrap-around read/write pointers plus an occupancy counter;
  - asynchronous active-low reset.
- The top level holds the FSM, the output registers and the response register.

## Test plan
- **Reset:** assert `rst_n`=0 mid-read with 2 requests queued, release → `busy`=0, `rsp_valid`=0, all `mem_*` outputs 0, `req_ready`=1.
- **Write then read:** write 0xA5 to address 2, then read address 2, `rsp_ready`=1 → `mem_write_en` 1 cycle; `rsp_valid` 4 cycles after the read accept with `rsp_rdata`=0xA5.
- **Back-pressure:** hold `rsp_ready`=0 after a read of address 1 (preloaded 0x3C), push 3 more requests → `req_ready`=0 after 2 are accepted; `rsp_rdata` holds 0x3C until `rsp_ready`=1.
- **All addresses:** write 0x11, 0x22, 0x33, 0x44 to addresses 0–3, then read 3, 0 → responses 0x44, then 0x11, in order.
- **Simultaneous push/pop at full:** FIFO full, IDLE pops while `req_valid`=1 → no push that cycle; occupancy goes 2→1, then the push is accepted the next cycle.
- **Assertion for all tests:** `mem_write_en && mem_read_en` never 1; `rsp_valid` never high outside RESP.
